// File: rtl/pong_pixel_packer.sv
// Pixel packer: buffers 12-bit pong pixels in a small FIFO tagged with a
// start-of-frame bit, then serializes each pixel as two bytes (hi, lo) over
// a valid/ready byte interface.
module pong_pixel_packer #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned LW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          p_tick,
   input  logic          vsync,
   input  logic [11:0]   rgb,
   output logic [7:0]    byte_data,
   output logic          byte_valid,
   input  logic          byte_ready,
   output logic          byte_sof,
   output logic          overflow,
   output logic [LW-1:0] fifo_level
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam logic [LW-1:0] DepthLw = LW'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StHi, StLo} state_e;

   state_e          state_q, state_d;
   logic [12:0]     mem_q [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic [12:0]     hold_q, hold_d;
   logic            vsync_dly_q, vsync_dly_d;
   logic            sof_pending_q, sof_pending_d;
   logic            overflow_q, overflow_d;
   logic [7:0]      byte_data_q, byte_data_d;
   logic            byte_valid_q, byte_valid_d;
   logic            byte_sof_q, byte_sof_d;

   logic            vs_rise;
   logic            not_empty;
   logic            pop;
   logic            wr_en;
   logic            sof_tag;

   // Next-state logic for FIFO bookkeeping, SOF tagging and the serializer
   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      level_d       = level_q;
      hold_d        = hold_q;
      sof_pending_d = sof_pending_q;
      overflow_d    = overflow_q;
      byte_data_d   = 8'h00;
      byte_valid_d  = 1'b0;
      byte_sof_d    = 1'b0;
      pop           = 1'b0;

      vsync_dly_d = vsync;
      vs_rise     = vsync & ~vsync_dly_q;
      not_empty   = (level_q != '0);

      case (state_q)
         StIdle: begin
            if (not_empty) begin
               pop     = 1'b1;
               state_d = StHi;
            end
         end
         StHi: begin
            if (byte_ready) begin
               state_d = StLo;
            end
         end
         StLo: begin
            if (byte_ready) begin
               // Refill straight from the FIFO so consecutive pixels have no bubble
               if (not_empty) begin
                  pop     = 1'b1;
                  state_d = StHi;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // A full FIFO still accepts a pixel when the head leaves in the same cycle
      wr_en   = p_tick & ((level_q != DepthLw) | pop);
      sof_tag = sof_pending_q | vs_rise;

      if (wr_en) begin
         wr_ptr_d      = wr_ptr_q + PW'(1);
         sof_pending_d = 1'b0;
      end else if (vs_rise) begin
         sof_pending_d = 1'b1;
      end

      if (p_tick && !wr_en) begin
         overflow_d = 1'b1;
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         hold_d   = mem_q[rd_ptr_q];
      end

      case ({wr_en, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      // Outputs are registered, so derive them from the state being entered
      case (state_d)
         StHi: begin
            byte_valid_d = 1'b1;
            byte_data_d  = {3'b000, hold_d[12], hold_d[11:8]};
            byte_sof_d   = hold_d[12];
         end
         StLo: begin
            byte_valid_d = 1'b1;
            byte_data_d  = hold_d[7:0];
            byte_sof_d   = 1'b0;
         end
         default: begin
            byte_valid_d = 1'b0;
            byte_data_d  = 8'h00;
            byte_sof_d   = 1'b0;
         end
      endcase
   end

   // Control state, pointers, hold register and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= StIdle;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         hold_q        <= '0;
         vsync_dly_q   <= 1'b0;
         sof_pending_q <= 1'b0;
         overflow_q    <= 1'b0;
         byte_data_q   <= 8'h00;
         byte_valid_q  <= 1'b0;
         byte_sof_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         hold_q        <= hold_d;
         vsync_dly_q   <= vsync_dly_d;
         sof_pending_q <= sof_pending_d;
         overflow_q    <= overflow_d;
         byte_data_q   <= byte_data_d;
         byte_valid_q  <= byte_valid_d;
         byte_sof_q    <= byte_sof_d;
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= {sof_tag, rgb};
      end
   end

   assign byte_data  = byte_data_q;
   assign byte_valid = byte_valid_q;
   assign byte_sof   = byte_sof_q;
   assign overflow   = overflow_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_pong_pixel_packer.sv
// Self-checking bench for pong_pixel_packer: scoreboard of expected bytes,
// table-driven pixel vectors and hand-written corner-case sequences.
module tb_pong_pixel_packer;

   logic        clk;
   logic        reset;
   logic        p_tick;
   logic        vsync;
   logic [11:0] rgb;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        byte_ready;
   logic        byte_sof;
   logic        overflow;
   logic [2:0]  fifo_level;

   int n_cmp  = 0;
   int n_fail = 0;
   int byte_cnt = 0;
   int sof_cnt  = 0;

   logic [8:0] sb [$];

   typedef struct {
      logic [11:0] rgb;
      logic        vs;
      logic        sof;
      logic [7:0]  hi;
      logic [7:0]  lo;
   } vec_t;

   vec_t tbl [8];

   pong_pixel_packer #(
      .FIFO_DEPTH(4),
      .LW(3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .p_tick    (p_tick),
      .vsync     (vsync),
      .rgb       (rgb),
      .byte_data (byte_data),
      .byte_valid(byte_valid),
      .byte_ready(byte_ready),
      .byte_sof  (byte_sof),
      .overflow  (overflow),
      .fifo_level(fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte monitor: a transfer seen here completes on the next rising edge
   always @(negedge clk) begin
      logic [8:0] want;
      if (reset && byte_valid && byte_ready) begin
         byte_cnt++;
         if (byte_sof) sof_cnt++;
         n_cmp++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL byte_unexpected: got sof=%0b data=%02h, want no byte", byte_sof,
                     byte_data);
         end else begin
            want = sb.pop_front();
            if ({byte_sof, byte_data} !== want) begin
               n_fail++;
               $display("FAIL byte: got sof=%0b data=%02h, want sof=%0b data=%02h", byte_sof,
                        byte_data, want[8], want[7:0]);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   task automatic push_exp(input logic [7:0] hi, input logic [7:0] lo, input logic sof);
      sb.push_back({sof, hi});
      sb.push_back({1'b0, lo});
   endtask

   task automatic drive(input logic [11:0] c, input logic vs);
      p_tick = 1'b1;
      rgb    = c;
      vsync  = vs;
   endtask

   // One pixel every two clocks; push expected bytes only if it should be accepted
   task automatic send_pix(input logic [11:0] c, input logic vs, input logic accept,
                           input logic sof);
      drive(c, vs);
      if (accept) push_exp({3'b000, sof, c[11:8]}, c[7:0], sof);
      tick();
      p_tick = 1'b0;
      vsync  = 1'b0;
      tick();
   endtask

   task automatic wait_drain();
      int n = 0;
      while (!(sb.size() == 0 && !byte_valid && fifo_level == 3'd0) && n < 4000) begin
         tick();
         n++;
      end
      n_cmp++;
      if (n >= 4000) begin
         n_fail++;
         $display("FAIL drain: got %0d bytes outstanding, want 0", sb.size());
      end
   endtask

   initial begin
      tbl[0] = '{rgb: 12'h123, vs: 1'b1, sof: 1'b1, hi: 8'h11, lo: 8'h23};
      tbl[1] = '{rgb: 12'hFFF, vs: 1'b0, sof: 1'b0, hi: 8'h0F, lo: 8'hFF};
      tbl[2] = '{rgb: 12'h000, vs: 1'b0, sof: 1'b0, hi: 8'h00, lo: 8'h00};
      tbl[3] = '{rgb: 12'h800, vs: 1'b1, sof: 1'b1, hi: 8'h18, lo: 8'h00};
      tbl[4] = '{rgb: 12'h07F, vs: 1'b0, sof: 1'b0, hi: 8'h00, lo: 8'h7F};
      tbl[5] = '{rgb: 12'hA5A, vs: 1'b0, sof: 1'b0, hi: 8'h0A, lo: 8'h5A};
      tbl[6] = '{rgb: 12'h5A5, vs: 1'b1, sof: 1'b1, hi: 8'h15, lo: 8'hA5};
      tbl[7] = '{rgb: 12'hF0F, vs: 1'b0, sof: 1'b0, hi: 8'h0F, lo: 8'h0F};

      reset      = 1'b0;
      p_tick     = 1'b0;
      vsync      = 1'b0;
      rgb        = 12'h000;
      byte_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", byte_valid, 0);
      chk("rst_data", byte_data, 0);
      chk("rst_sof", byte_sof, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_level", fifo_level, 0);
      reset = 1'b1;
      tick();

      // Basic packing and latency: vsync rises, then one pixel
      byte_ready = 1'b1;
      vsync = 1'b1;
      tick();
      drive(12'hABC, 1'b1);
      push_exp(8'h1A, 8'hBC, 1'b1);
      tick();
      p_tick = 1'b0;
      vsync  = 1'b0;
      chk("lat_n1_level", fifo_level, 1);
      chk("lat_n1_valid", byte_valid, 0);
      tick();
      chk("lat_n2_valid", byte_valid, 1);
      chk("lat_n2_data", byte_data, 8'h1A);
      chk("lat_n2_sof", byte_sof, 1);
      wait_drain();

      // Table vectors at full rate, vsync edges coinciding with pixels
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].rgb, tbl[i].vs);
         push_exp(tbl[i].hi, tbl[i].lo, tbl[i].sof);
         tick();
         p_tick = 1'b0;
         vsync  = 1'b0;
         tick();
      end
      wait_drain();
      chk("tput_ovf", overflow, 0);

      // Backpressure: first pixel lands in the hold register, next four fill the FIFO
      byte_ready = 1'b0;
      send_pix(12'h101, 1'b0, 1'b1, 1'b0);
      chk("bp_valid", byte_valid, 1);
      for (int k = 2; k <= 5; k++) begin
         send_pix(12'(k * 12'h101), 1'b0, 1'b1, 1'b0);
         chk("bp_stable_data", byte_data, 8'h01);
         chk("bp_stable_sof", byte_sof, 0);
      end
      chk("bp_level_full", fifo_level, 4);
      chk("bp_ovf_before", overflow, 0);
      send_pix(12'h606, 1'b0, 1'b0, 1'b0);
      chk("bp_ovf_set", overflow, 1);
      chk("bp_level_after_drop", fifo_level, 4);

      // Simultaneous push and pop at full, FSM in LO
      byte_ready = 1'b1;
      tick();
      chk("sim_lo_data", byte_data, 8'h01);
      drive(12'h707, 1'b0);
      push_exp(8'h07, 8'h07, 1'b0);
      tick();
      p_tick = 1'b0;
      chk("sim_level", fifo_level, 4);
      chk("sim_ovf", overflow, 1);
      wait_drain();
      chk("ovf_sticky", overflow, 1);

      // SOF survives a dropped pixel while full
      byte_ready = 1'b0;
      sof_cnt = 0;
      for (int k = 1; k <= 5; k++) begin
         send_pix(12'hC00 + 12'(k), 1'b0, 1'b1, 1'b0);
      end
      chk("sofdrop_level", fifo_level, 4);
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      tick();
      send_pix(12'hC06, 1'b0, 1'b0, 1'b0);
      chk("sofdrop_level_hold", fifo_level, 4);
      byte_ready = 1'b1;
      tick();
      tick();
      send_pix(12'hC07, 1'b0, 1'b1, 1'b1);
      send_pix(12'hC08, 1'b0, 1'b1, 1'b0);
      wait_drain();
      chk("sofdrop_sof_count", sof_cnt, 1);

      // Reset mid-operation with one pixel held and three queued
      byte_ready = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         send_pix(12'hD00 + 12'(k), 1'b0, 1'b1, 1'b0);
      end
      chk("mid_valid", byte_valid, 1);
      chk("mid_level", fifo_level, 3);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_valid", byte_valid, 0);
      chk("mid_rst_level", fifo_level, 0);
      chk("mid_rst_ovf", overflow, 0);
      chk("mid_rst_data", byte_data, 0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      byte_ready = 1'b1;
      chk("post_rst_level", fifo_level, 0);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("post_rst_no_stale", byte_valid, 0);
      end

      // Full 129x65 frame at one pixel per two clocks
      byte_cnt = 0;
      sof_cnt  = 0;
      vsync = 1'b1;
      tick();
      tick();
      vsync = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 129 * 65; i++) begin
         send_pix(12'(i), 1'b0, 1'b1, (i == 0));
      end
      wait_drain();
      chk("frame_bytes", byte_cnt, 16770);
      chk("frame_sof", sof_cnt, 1);
      chk("frame_ovf", overflow, 0);
      chk("sb_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
